// File: rtl/dmem_ctrl.sv
// Data-memory controller for the single-cycle MIPS data section.
// Big-endian byte/halfword/word access into a DEPTH x 32-bit array,
// base-address window decode with fault reporting, a fixed-latency
// response pipeline and optional zero-fill of the array after reset.
module dmem_ctrl #(
    parameter int                DEPTH      = 512,
    parameter int                ADDR_W     = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(32'h1001_0000),
    parameter int                READ_LAT   = 1,
    parameter bit                INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_signed,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [1:0]        rsp_fault
);

    localparam int                IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN  = ADDR_W'(DEPTH * 4);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    localparam logic [1:0] FLT_OK    = 2'b00;
    localparam logic [1:0] FLT_ALIGN = 2'b01;
    localparam logic [1:0] FLT_RANGE = 2'b10;
    localparam logic [1:0] FLT_SIZE  = 2'b11;

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    // Lanes touched by an access; lane 0 is the most significant byte.
    function automatic logic [31:0] lane_mask(input logic [1:0] size,
                                              input logic [1:0] lane);
        logic [31:0] m;
        case (size)
            SZ_BYTE: m = 32'hFF00_0000 >> {lane, 3'b000};
            SZ_HALF: m = 32'hFFFF_0000 >> {lane[1], 4'b0000};
            SZ_WORD: m = 32'hFFFF_FFFF;
            default: m = 32'h0000_0000;
        endcase
        return m;
    endfunction

    // Move right-justified store data up into its big-endian lane position.
    function automatic logic [31:0] lane_place(input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic [31:0] wdata);
        logic [31:0] p;
        case (size)
            SZ_BYTE: p = {wdata[7:0], 24'h00_0000} >> {lane, 3'b000};
            SZ_HALF: p = {wdata[15:0], 16'h0000} >> {lane[1], 4'b0000};
            SZ_WORD: p = wdata;
            default: p = 32'h0000_0000;
        endcase
        return p;
    endfunction

    // Pull the addressed lane out of a word and sign/zero extend it.
    function automatic logic [31:0] lane_extract(input logic [1:0]  size,
                                                 input logic [1:0]  lane,
                                                 input logic        sgn,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        logic [31:0] r;
        case (size)
            SZ_BYTE: begin
                sh = word << {lane, 3'b000};
                r  = {{24{sgn & sh[31]}}, sh[31:24]};
            end
            SZ_HALF: begin
                sh = word << {lane[1], 4'b0000};
                r  = {{16{sgn & sh[31]}}, sh[31:16]};
            end
            SZ_WORD: begin
                sh = word;
                r  = word;
            end
            default: begin
                sh = 32'h0000_0000;
                r  = 32'h0000_0000;
            end
        endcase
        return r;
    endfunction

    // Control state
    state_t           state_q, state_d;
    logic [IDX_W-1:0] clr_cnt_q, clr_cnt_d;
    logic             ready_q, ready_d;

    // Storage
    logic [31:0]      mem_q [DEPTH];

    // Request decode
    logic              accept_s;
    logic [ADDR_W-1:0] offset_s;
    logic              below_s;
    logic              above_s;
    logic [IDX_W-1:0]  idx_s;
    logic [1:0]        lane_s;
    logic [1:0]        fault_s;
    logic [31:0]       rd_word_s;
    logic [31:0]       load_val_s;

    // Array write port
    logic              mem_we_s;
    logic [IDX_W-1:0]  mem_widx_s;
    logic [31:0]       mem_wdata_s;

    // Response pipeline, stage READ_LAT-1 drives the outputs
    logic              pipe_vld_q  [READ_LAT];
    logic [31:0]       pipe_data_q [READ_LAT];
    logic [1:0]        pipe_flt_q  [READ_LAT];
    logic              pipe_vld_d  [READ_LAT];
    logic [31:0]       pipe_data_d [READ_LAT];
    logic [1:0]        pipe_flt_d  [READ_LAT];

    assign accept_s  = req_valid & ready_q;
    assign offset_s  = req_addr - BASE_ADDR;
    assign below_s   = (req_addr < BASE_ADDR);
    assign above_s   = (offset_s >= SPAN);
    assign idx_s     = offset_s[IDX_W+1:2];
    assign lane_s    = offset_s[1:0];
    assign rd_word_s = mem_q[idx_s];

    // Fault classification in priority order: size, range, alignment.
    always_comb begin
        fault_s = FLT_OK;
        if (req_size == SZ_ILL) begin
            fault_s = FLT_SIZE;
        end else if (below_s || above_s) begin
            fault_s = FLT_RANGE;
        end else if (((req_size == SZ_HALF) && lane_s[0]) ||
                     ((req_size == SZ_WORD) && (lane_s != 2'b00))) begin
            fault_s = FLT_ALIGN;
        end else begin
            fault_s = FLT_OK;
        end
    end

    // Load result: extracted lane for good loads, zero otherwise.
    always_comb begin
        load_val_s = 32'h0000_0000;
        if (!req_we && (fault_s == FLT_OK)) begin
            load_val_s = lane_extract(req_size, lane_s, req_signed, rd_word_s);
        end else begin
            load_val_s = 32'h0000_0000;
        end
    end

    // Array write selection: clear sweep, else merged store, never under reset.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_widx_s  = {IDX_W{1'b0}};
        mem_wdata_s = 32'h0000_0000;
        if (rst) begin
            mem_we_s = 1'b0;
        end else if (state_q == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_widx_s  = clr_cnt_q;
            mem_wdata_s = 32'h0000_0000;
        end else if (accept_s && req_we && (fault_s == FLT_OK)) begin
            mem_we_s    = 1'b1;
            mem_widx_s  = idx_s;
            mem_wdata_s = (rd_word_s & ~lane_mask(req_size, lane_s)) |
                          (lane_place(req_size, lane_s, req_wdata) &
                           lane_mask(req_size, lane_s));
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Array storage; contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem_q[mem_widx_s] <= mem_wdata_s;
        end
    end

    // Next-state logic for the clear sweep and the ready flag.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ready_d   = ready_q;
        case (state_q)
            ST_CLEAR: begin
                if (clr_cnt_q == IDX_W'(DEPTH - 1)) begin
                    state_d   = ST_RUN;
                    clr_cnt_d = {IDX_W{1'b0}};
                    ready_d   = 1'b1;
                end else begin
                    clr_cnt_d = clr_cnt_q + IDX_W'(1);
                    ready_d   = 1'b0;
                end
            end
            ST_RUN: begin
                ready_d = 1'b1;
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = {IDX_W{1'b0}};
                ready_d   = 1'b0;
            end
        endcase
    end

    // Control state registers; reset parks in CLEAR at word 0 (or RUN).
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= INIT_CLEAR ? ST_CLEAR : ST_RUN;
            clr_cnt_q <= {IDX_W{1'b0}};
            ready_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ready_q   <= ready_d;
        end
    end

    // Pipeline shift: stage 0 captures the accepted request's response.
    always_comb begin
        pipe_vld_d[0]  = accept_s;
        pipe_data_d[0] = 32'h0000_0000;
        pipe_flt_d[0]  = FLT_OK;
        if (accept_s) begin
            pipe_data_d[0] = load_val_s;
            pipe_flt_d[0]  = fault_s;
        end else begin
            pipe_data_d[0] = 32'h0000_0000;
            pipe_flt_d[0]  = FLT_OK;
        end
        for (int i = 1; i < READ_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_data_q[i-1];
            pipe_flt_d[i]  = pipe_flt_q[i-1];
        end
    end

    // Pipeline registers; reset discards every in-flight response.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld_q[i]  <= 1'b0;
                pipe_data_q[i] <= 32'h0000_0000;
                pipe_flt_q[i]  <= FLT_OK;
            end
        end else begin
            for (int i = 0; i < READ_LAT; i++) begin
                pipe_vld_q[i]  <= pipe_vld_d[i];
                pipe_data_q[i] <= pipe_data_d[i];
                pipe_flt_q[i]  <= pipe_flt_d[i];
            end
        end
    end

    assign req_ready = ready_q;
    assign rsp_valid = pipe_vld_q[READ_LAT-1];
    assign rsp_rdata = pipe_data_q[READ_LAT-1];
    assign rsp_fault = pipe_flt_q[READ_LAT-1];

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
Parametrised data-memory block for the single-cycle MIPS core's data section, the successor to the plain word RAM. It adds:
- byte, halfword and word loads and stores on big-endian lanes, with sign or zero extension on loads;
- a base-address window with alignment, range and size fault reporting;
- a valid/ready request port and a configurable read-latency pipeline;
- optional zero-clearing of the whole array after reset.

It sits between the core's memory stage and the data array.

Parameters:
DEPTH, 512, number of 32-bit words in the array (power of two).
ADDR_W, 32, request address width.
BASE_ADDR, 32'h10010000, byte address of word 0.
READ_LAT, 1, cycles from request acceptance to response; legal range 1..4.
INIT_CLEAR, 1, when 1, the array is zero-filled after reset.

Ports:
clk  in  1  clock; all state updates on its rising edge.
rst  in  1  synchronous active-high reset.
req_valid  in  1  request present.
req_ready  out  1  block can accept a request this cycle.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal.
req_signed  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
req_addr  in  ADDR_W  byte address.
req_wdata  in  32  store data, right-justified (byte in [7:0], halfword in [15:0]).
rsp_valid  out  1  response strobe, one cycle per accepted request.
rsp_rdata  out  32  load result; 0 for stores and for faulted requests.
rsp_fault  out  2  00 ok, 01 misaligned, 10 out of range, 11 illegal size.

Behaviour:
Reset:
- Applies only when rst is high at a clock edge.
- Outputs: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_fault=0.
- All in-flight pipeline entries are discarded, including when rst rises mid-operation.
- Array contents are not affected by reset itself.

State machine (CLEAR, RUN):
- After rst falls: enter CLEAR if INIT_CLEAR=1, otherwise RUN.
- CLEAR: a word counter runs 0..DEPTH-1 writing 0, one word per cycle; req_ready=0. Move to RUN after word DEPTH-1 is written, so DEPTH cycles in total.
- rst during CLEAR restarts the clear from word 0.
- RUN: req_ready=1 every cycle.

Acceptance:
- A request is accepted on an edge where req_valid && req_ready.
- At most one request per cycle; no response backpressure.

Decode (offset = req_addr - BASE_ADDR):
- Out of range when req_addr < BASE_ADDR or offset >= DEPTH*4.
- Word index = offset[log2(DEPTH)+1:2].
- Misaligned: halfword with offset[0]=1, or word with offset[1:0]!=0.
- Fault priority: illegal size > out of range > misaligned.
- A faulted request never writes the array.

Lanes (big-endian):
- Byte offset 00 selects bits [31:24], 11 selects bits [7:0].
- Halfword offset[1]=0 selects bits [31:16].

Stores:
- Commit on the acceptance edge.
- Only the selected lanes change; other lanes keep their prior value.

Loads:
- Read the array at acceptance (value after any earlier-accepted store).
- Extract the selected lane and extend per req_signed. Word loads ignore req_signed.

Response pipeline:
- Every accepted request, load or store, faulted or not, yields exactly one rsp_valid pulse.
- The pulse comes exactly READ_LAT cycles after acceptance, in acceptance order.
- rsp_rdata and rsp_fault are valid only while rsp_valid=1 and are 0 otherwise.
- A load accepted the cycle after a store to the same word returns the new data.

Test Plan:
1. INIT_CLEAR=1, DEPTH=512: pulse rst -> req_ready=0 for exactly 512 cycles, then 1; lw 0x10010010 -> rdata 0x00000000, fault 00.
2. sw 0x10010004 = 0xAABBCCDD; then lb signed 0x10010004 -> 0xFFFFFFAA; lbu 0x10010007 -> 0x000000DD; lh signed 0x10010006 -> 0xFFFFCCDD; lhu 0x10010004 -> 0x0000AABB.
3. sb 0x10010005 wdata 0x00000011 -> lw 0x10010004 returns 0xAA11CCDD; sh 0x10010006 wdata 0x00001234 -> lw returns 0xAA111234.
4. lw 0x10010002 -> fault 01, rdata 0; sw 0x10010800 (offset DEPTH*4) -> fault 10, no write; lw 0x1000FFFC -> fault 10; req_size=11 at a misaligned address -> fault 11.
5. READ_LAT=3: four back-to-back loads -> each rsp_valid exactly 3 cycles after its acceptance, data in order; a sw followed next cycle by lw of the same word returns the stored value.
6. READ_LAT=2: rst asserted one cycle after two loads are accepted -> rsp_valid stays 0 (no stale responses); in CLEAR, reassert rst at count 100 -> the clear restarts and req_ready rises 512 cycles after rst falls.
